// File: rtl/rob_param_pkg.sv
// Shared ROB definitions: per-entry state encoding and default geometry.
package rob_param_pkg;

  localparam int ROB_STATE_LEN = 2;

  typedef enum logic [ROB_STATE_LEN-1:0] {
    ROB_IDLE     = 2'd0,
    ROB_PENDING  = 2'd1,
    ROB_FINISHED = 2'd2
  } rob_state_e;

  localparam int DEF_DEPTH  = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_PC_W   = 4;
  localparam int DEF_RD_W   = 2;

endpackage

// File: rtl/rob_param_ptr.sv
// Wrapping ROB pointer with a phase bit; clear wins over increment.
// Updates on the next edge; no backpressure of its own.
module rob_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/rob_param.sv
// Reorder buffer: in-order dispatch/commit, out-of-order completion, operand lookup with bypass.
// Commit outputs are combinational from head; dispatch stalls on registered full, commit waits on cmt_ready.
module rob_param
  import rob_param_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int TAG_W  = $clog2(DEPTH),
  parameter int DATA_W = DEF_DATA_W,
  parameter int PC_W   = DEF_PC_W,
  parameter int RD_W   = DEF_RD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [PC_W-1:0]   disp_pc,
  input  logic              disp_wen,
  input  logic [RD_W-1:0]   disp_rd,
  input  logic              disp_is_br,
  input  logic              disp_pred_tk,
  output logic [TAG_W-1:0]  disp_tag,
  input  logic              cmpl_valid,
  input  logic [TAG_W-1:0]  cmpl_tag,
  input  logic [DATA_W-1:0] cmpl_data,
  input  logic              cmpl_taken,
  input  logic [PC_W-1:0]   cmpl_next_pc,
  input  logic [TAG_W-1:0]  lkA_tag,
  output logic              lkA_ready,
  output logic [DATA_W-1:0] lkA_data,
  input  logic [TAG_W-1:0]  lkB_tag,
  output logic              lkB_ready,
  output logic [DATA_W-1:0] lkB_data,
  output logic              cmt_valid,
  input  logic              cmt_ready,
  output logic              cmt_wen,
  output logic [RD_W-1:0]   cmt_rd,
  output logic [DATA_W-1:0] cmt_data,
  output logic [TAG_W-1:0]  cmt_tag,
  output logic              cmt_squash,
  output logic [PC_W-1:0]   cmt_next_pc,
  output logic [TAG_W:0]    count
);

  rob_state_e        state_q   [DEPTH];
  rob_state_e        state_d   [DEPTH];
  logic [DATA_W-1:0] data_q    [DEPTH];
  logic [DATA_W-1:0] data_d    [DEPTH];
  logic [PC_W-1:0]   pc_q      [DEPTH];
  logic [PC_W-1:0]   pc_d      [DEPTH];
  logic [PC_W-1:0]   npc_q     [DEPTH];
  logic [PC_W-1:0]   npc_d     [DEPTH];
  logic [RD_W-1:0]   rd_q      [DEPTH];
  logic [RD_W-1:0]   rd_d      [DEPTH];
  logic              wen_q     [DEPTH];
  logic              wen_d     [DEPTH];
  logic              is_br_q   [DEPTH];
  logic              is_br_d   [DEPTH];
  logic              pred_tk_q [DEPTH];
  logic              pred_tk_d [DEPTH];
  logic              taken_q   [DEPTH];
  logic              taken_d   [DEPTH];

  logic [TAG_W:0]   head, tail;
  logic [TAG_W-1:0] head_idx, tail_idx;
  logic             full, empty, disp_fire, cmt_fire, squash;
  logic             lka_byp, lkb_byp;

  assign head_idx = head[TAG_W-1:0];
  assign tail_idx = tail[TAG_W-1:0];
  assign full     = (head[TAG_W] != tail[TAG_W]) && (head_idx == tail_idx);
  assign empty    = (head == tail);
  assign count    = tail - head;

  assign disp_ready = !full;
  assign disp_tag   = tail_idx;
  assign disp_fire  = disp_valid && disp_ready;

  assign cmt_valid   = !empty && (state_q[head_idx] == ROB_FINISHED);
  assign cmt_fire    = cmt_valid && cmt_ready;
  assign cmt_tag     = head_idx;
  assign cmt_wen     = cmt_valid && wen_q[head_idx];
  assign cmt_rd      = cmt_valid ? rd_q[head_idx]   : '0;
  assign cmt_data    = cmt_valid ? data_q[head_idx] : '0;
  assign cmt_next_pc = cmt_valid ? npc_q[head_idx]  : '0;
  assign cmt_squash  = cmt_valid && is_br_q[head_idx] && (pred_tk_q[head_idx] != taken_q[head_idx]);

  // A mispredicted commit squashes exactly like an external flush.
  assign squash = flush || (cmt_fire && cmt_squash);

  assign lka_byp   = cmpl_valid && (cmpl_tag == lkA_tag) && (state_q[lkA_tag] == ROB_PENDING);
  assign lkA_ready = lka_byp || (state_q[lkA_tag] == ROB_FINISHED);
  assign lkA_data  = lka_byp ? cmpl_data :
                     ((state_q[lkA_tag] == ROB_FINISHED) ? data_q[lkA_tag] : '0);

  assign lkb_byp   = cmpl_valid && (cmpl_tag == lkB_tag) && (state_q[lkB_tag] == ROB_PENDING);
  assign lkB_ready = lkb_byp || (state_q[lkB_tag] == ROB_FINISHED);
  assign lkB_data  = lkb_byp ? cmpl_data :
                     ((state_q[lkB_tag] == ROB_FINISHED) ? data_q[lkB_tag] : '0);

  rob_ptr #(.W(TAG_W+1)) u_head (.clk(clk), .rst(rst), .clr(squash), .inc(cmt_fire),  .ptr(head));
  rob_ptr #(.W(TAG_W+1)) u_tail (.clk(clk), .rst(rst), .clr(squash), .inc(disp_fire), .ptr(tail));

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    pc_d      = pc_q;
    npc_d     = npc_q;
    rd_d      = rd_q;
    wen_d     = wen_q;
    is_br_d   = is_br_q;
    pred_tk_d = pred_tk_q;
    taken_d   = taken_q;
    if (squash) begin
      for (int i = 0; i < DEPTH; i++) state_d[i] = ROB_IDLE;
    end else begin
      // Slots touched by completion, commit and dispatch are always distinct by state.
      if (cmpl_valid && (state_q[cmpl_tag] == ROB_PENDING)) begin
        state_d[cmpl_tag] = ROB_FINISHED;
        data_d[cmpl_tag]  = cmpl_data;
        taken_d[cmpl_tag] = cmpl_taken;
        npc_d[cmpl_tag]   = cmpl_next_pc;
      end
      if (cmt_fire) state_d[head_idx] = ROB_IDLE;
      if (disp_fire) begin
        state_d[tail_idx]   = ROB_PENDING;
        pc_d[tail_idx]      = disp_pc;
        wen_d[tail_idx]     = disp_wen;
        rd_d[tail_idx]      = disp_rd;
        is_br_d[tail_idx]   = disp_is_br;
        pred_tk_d[tail_idx] = disp_pred_tk;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= ROB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q    <= data_d;
    pc_q      <= pc_d;
    npc_q     <= npc_d;
    rd_q      <= rd_d;
    wen_q     <= wen_d;
    is_br_q   <= is_br_d;
    pred_tk_q <= pred_tk_d;
    taken_q   <= taken_d;
  end

endmodule

// File: tb/tb_rob_param.sv
// Scoreboarded bench for rob_param against a queue-based ROB model.
module tb_rob_param;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst, flush;
  logic       disp_valid, disp_ready, disp_wen, disp_is_br, disp_pred_tk;
  logic [3:0] disp_pc;
  logic [1:0] disp_rd;
  logic [2:0] disp_tag;
  logic       cmpl_valid, cmpl_taken;
  logic [2:0] cmpl_tag;
  logic [7:0] cmpl_data;
  logic [3:0] cmpl_next_pc;
  logic [2:0] lkA_tag, lkB_tag;
  logic       lkA_ready, lkB_ready;
  logic [7:0] lkA_data, lkB_data;
  logic       cmt_valid, cmt_ready, cmt_wen, cmt_squash;
  logic [1:0] cmt_rd;
  logic [7:0] cmt_data;
  logic [2:0] cmt_tag;
  logic [3:0] cmt_next_pc;
  logic [3:0] count;

  always #5 clk = ~clk;

  rob_param dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_pc(disp_pc), .disp_wen(disp_wen),
    .disp_rd(disp_rd), .disp_is_br(disp_is_br), .disp_pred_tk(disp_pred_tk), .disp_tag(disp_tag),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_data(cmpl_data),
    .cmpl_taken(cmpl_taken), .cmpl_next_pc(cmpl_next_pc),
    .lkA_tag(lkA_tag), .lkA_ready(lkA_ready), .lkA_data(lkA_data),
    .lkB_tag(lkB_tag), .lkB_ready(lkB_ready), .lkB_data(lkB_data),
    .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_wen(cmt_wen), .cmt_rd(cmt_rd),
    .cmt_data(cmt_data), .cmt_tag(cmt_tag), .cmt_squash(cmt_squash),
    .cmt_next_pc(cmt_next_pc), .count(count)
  );

  typedef struct {
    logic [3:0] count;
    logic       drdy;
    logic [2:0] dtag;
    logic       cv;
    logic       ar;
    logic [7:0] ad;
    logic       br;
    logic [7:0] bd;
  } stat_t;

  typedef struct {
    logic [2:0] tag;
    logic       wen;
    logic [1:0] rd;
    logic [7:0] data;
    logic       sq;
    logic [3:0] npc;
  } cmt_t;

  stat_t stat_q[$];
  cmt_t  cmt_q[$];
  int    pass_cnt = 0;
  int    total_cnt = 0;

  // Reference model: program-ordered list of tags plus per-tag records.
  int         mq[$];
  int         m_next;
  bit         m_inflight [DEPTH];
  bit         m_done     [DEPTH];
  logic [7:0] m_data     [DEPTH];
  logic [3:0] m_npc      [DEPTH];
  logic [1:0] m_rd       [DEPTH];
  bit         m_wen      [DEPTH];
  bit         m_br       [DEPTH];
  bit         m_ptk      [DEPTH];
  bit         m_tk       [DEPTH];

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
  endfunction

  function automatic void model_clear();
    mq.delete();
    m_next = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_inflight[i] = 0;
      m_done[i] = 0;
    end
  endfunction

  function automatic void exp_lk(input logic [2:0] t, output logic r, output logic [7:0] d);
    r = 1'b0;
    d = 8'h00;
    if (m_inflight[t]) begin
      if (m_done[t]) begin
        r = 1'b1;
        d = m_data[t];
      end else if (cmpl_valid && cmpl_tag == t) begin
        r = 1'b1;
        d = cmpl_data;
      end
    end
  endfunction

  task automatic step();
    stat_t s;
    cmt_t  c;
    bit    fire, sq;
    int    h, sz, t;
    s.count = 4'(mq.size());
    s.drdy  = mq.size() < DEPTH;
    s.dtag  = 3'(m_next);
    s.cv    = (mq.size() > 0) && m_done[mq[0]];
    exp_lk(lkA_tag, s.ar, s.ad);
    exp_lk(lkB_tag, s.br, s.bd);
    stat_q.push_back(s);
    fire = s.cv && cmt_ready;
    sq = 0;
    if (fire) begin
      h = mq[0];
      c.tag = 3'(h); c.wen = m_wen[h]; c.rd = m_rd[h]; c.data = m_data[h];
      c.sq = m_br[h] && (m_ptk[h] != m_tk[h]); c.npc = m_npc[h];
      sq = c.sq;
      cmt_q.push_back(c);
    end
    @(posedge clk);
    if (rst || flush || (fire && sq)) begin
      model_clear();
    end else begin
      if (cmpl_valid && m_inflight[cmpl_tag] && !m_done[cmpl_tag]) begin
        m_done[cmpl_tag] = 1; m_data[cmpl_tag] = cmpl_data;
        m_tk[cmpl_tag] = cmpl_taken; m_npc[cmpl_tag] = cmpl_next_pc;
      end
      sz = mq.size();
      if (fire) begin
        h = mq.pop_front();
        m_inflight[h] = 0;
      end
      if (disp_valid && sz < DEPTH) begin
        t = m_next;
        m_inflight[t] = 1; m_done[t] = 0; m_wen[t] = disp_wen; m_rd[t] = disp_rd;
        m_br[t] = disp_is_br; m_ptk[t] = disp_pred_tk;
        mq.push_back(t);
        m_next = (m_next + 1) % DEPTH;
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    stat_t s;
    cmt_t  c;
    if (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      chk("count", 32'(count), 32'(s.count));
      chk("disp_ready", 32'(disp_ready), 32'(s.drdy));
      chk("disp_tag", 32'(disp_tag), 32'(s.dtag));
      chk("cmt_valid", 32'(cmt_valid), 32'(s.cv));
      chk("lkA_ready", 32'(lkA_ready), 32'(s.ar));
      chk("lkA_data", 32'(lkA_data), 32'(s.ad));
      chk("lkB_ready", 32'(lkB_ready), 32'(s.br));
      chk("lkB_data", 32'(lkB_data), 32'(s.bd));
    end
    if (cmt_valid === 1'b1 && cmt_ready === 1'b1) begin
      if (cmt_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_commit: tag %0d committed, none expected at %0t", cmt_tag, $time);
      end else begin
        c = cmt_q.pop_front();
        chk("cmt_tag", 32'(cmt_tag), 32'(c.tag));
        chk("cmt_wen", 32'(cmt_wen), 32'(c.wen));
        chk("cmt_rd", 32'(cmt_rd), 32'(c.rd));
        chk("cmt_data", 32'(cmt_data), 32'(c.data));
        chk("cmt_squash", 32'(cmt_squash), 32'(c.sq));
        chk("cmt_next_pc", 32'(cmt_next_pc), 32'(c.npc));
      end
    end
  end

  task automatic idle_inputs();
    flush = 0; disp_valid = 0; disp_pc = 0; disp_wen = 0; disp_rd = 0; disp_is_br = 0;
    disp_pred_tk = 0; cmpl_valid = 0; cmpl_tag = 0; cmpl_data = 0; cmpl_taken = 0;
    cmpl_next_pc = 0; cmt_ready = 0; lkA_tag = 0; lkB_tag = 0;
  endtask

  task automatic dispatch(input int n, input bit br, input bit ptk);
    for (int i = 0; i < n; i++) begin
      disp_valid = 1; disp_pc = 4'(i); disp_wen = 1; disp_rd = 2'(i); disp_is_br = br;
      disp_pred_tk = ptk;
      step();
    end
    disp_valid = 0; disp_is_br = 0;
  endtask

  task automatic complete(input logic [2:0] t, input logic [7:0] d, input bit tk, input logic [3:0] np);
    cmpl_valid = 1; cmpl_tag = t; cmpl_data = d; cmpl_taken = tk; cmpl_next_pc = np;
    step();
    cmpl_valid = 0;
  endtask

  initial begin
    model_clear();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    step();
    rst = 0;
    step();
    // Fill to full, then commit tag0 while a dispatch is blocked.
    dispatch(8, 0, 0);
    step();
    complete(3'd0, 8'h11, 0, 4'd1);
    cmt_ready = 1; disp_valid = 1; step();
    cmt_ready = 0; step();
    disp_valid = 0; step();
    // Out-of-order completion, in-order commit.
    flush = 1; step(); flush = 0;
    dispatch(3, 0, 0);
    cmt_ready = 1;
    lkA_tag = 2; complete(3'd2, 8'hA2, 0, 4'd3);
    lkA_tag = 1; complete(3'd1, 8'hA1, 0, 4'd2);
    lkA_tag = 0; complete(3'd0, 8'hA0, 0, 4'd1);
    repeat (3) step();
    cmt_ready = 0;
    // Same-cycle bypass, then a duplicate completion that must be ignored.
    dispatch(1, 0, 0);
    lkA_tag = 3; lkB_tag = 3;
    complete(3'd3, 8'h5A, 0, 4'd4);
    complete(3'd3, 8'hFF, 1, 4'd7);
    step();
    cmt_ready = 1; step(); cmt_ready = 0;
    // Mispredicted branch at head squashes; a same-cycle dispatch is lost.
    dispatch(1, 1, 0);
    dispatch(1, 0, 0);
    complete(3'd4, 8'h44, 1, 4'd9);
    cmt_ready = 1; disp_valid = 1; step();
    cmt_ready = 0; disp_valid = 0;
    for (int i = 0; i < DEPTH; i++) begin
      lkA_tag = 3'(i); lkB_tag = 3'(DEPTH - 1 - i); step();
    end
    // Flush with 5 in flight, then reset during a commit.
    dispatch(5, 0, 0);
    flush = 1; step(); flush = 0;
    step();
    dispatch(2, 0, 0);
    complete(3'd0, 8'h77, 0, 4'd5);
    cmt_ready = 1; rst = 1; step();
    rst = 0; cmt_ready = 0; step();
    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      disp_valid   = $urandom_range(0, 99) < 60;
      disp_pc      = 4'($urandom);
      disp_wen     = 1'($urandom);
      disp_rd      = 2'($urandom);
      disp_is_br   = $urandom_range(0, 99) < 15;
      disp_pred_tk = 1'($urandom);
      cmpl_valid   = $urandom_range(0, 99) < 60;
      if (mq.size() > 0 && $urandom_range(0, 99) < 80)
        cmpl_tag = 3'(mq[$urandom_range(0, mq.size() - 1)]);
      else
        cmpl_tag = 3'($urandom);
      cmpl_data    = 8'($urandom);
      cmpl_taken   = 1'($urandom);
      cmpl_next_pc = 4'($urandom);
      cmt_ready    = $urandom_range(0, 99) < 70;
      flush        = $urandom_range(0, 99) < 2;
      rst          = $urandom_range(0, 199) < 1;
      lkA_tag      = 3'($urandom);
      lkB_tag      = ($urandom_range(0, 1) == 1) ? cmpl_tag : 3'($urandom);
      step();
    end
    idle_inputs();
    rst = 0;
    step();
    @(negedge clk);
    #1;
    chk("commit_queue_drained", 32'(cmt_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
